swc_page_alloc_arbiter: RTL and testbench
=========================================

Name: swc_page_alloc_arbiter

Overview:
- Front-end to swc_page_allocator. Arbitrates page alloc/free requests from g_num_ports input-block requesters onto the allocator's single-operation interface.
- Issues one operation at a time and waits for the allocator to return idle. Returns the allocated page address to the granted requester with a one-cycle ack.
- Sits between the per-port input blocks (upstream) and swc_page_allocator (downstream).

Parameters:
g_num_ports, 4, number of requesting ports (1..16)
g_page_addr_bits, 11, page address width (matches allocator)
g_use_count_bits, 4, use-count width (matches allocator)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
req_alloc_i  in  g_num_ports  per-port alloc request, level, held until ack
req_free_i  in  g_num_ports  per-port free request, level, held until ack
req_usecnt_i  in  g_num_ports*g_use_count_bits  per-port use count for alloc (port p at slice p)
req_pgaddr_i  in  g_num_ports*g_page_addr_bits  per-port page to free
ack_o  out  g_num_ports  one-cycle completion strobe to granted port
pgaddr_o  out  g_page_addr_bits  allocated page, valid with ack_o of an alloc
nomem_o  out  1  registered copy of mm_nomem_i
mm_alloc_o  out  1  alloc pulse to allocator
mm_free_o  out  1  free pulse to allocator
mm_usecnt_o  out  g_use_count_bits  use count to allocator
mm_pgaddr_o  out  g_page_addr_bits  page to free, to allocator
mm_pgaddr_i  in  g_page_addr_bits  allocator result
mm_pgaddr_valid_i  in  1  allocator result valid
mm_idle_i  in  1  allocator idle
mm_nomem_i  in  1  allocator has no free pages

Behaviour:
- Reset: all outputs 0, FSM=IDLE, round-robin pointer=0, captured address=0.
- FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - Eligible port p: req_free_i[p], or req_alloc_i[p] with mm_nomem_i=0.
  - If mm_idle_i=1 and any port is eligible, pick the first eligible port at or after the pointer (wrap-around).
  - Register the port index, op (free wins if both requests are set on one port), usecnt and pgaddr. Go to ISSUE.
- ISSUE: exactly one cycle.
  - Drive mm_alloc_o or mm_free_o =1, with mm_usecnt_o/mm_pgaddr_o from the registered values. Go to WAIT.
  - mm_usecnt_o/mm_pgaddr_o hold stable from ISSUE through DONE.
- WAIT:
  - On mm_pgaddr_valid_i=1, capture mm_pgaddr_i.
  - The first cycle with mm_idle_i=1 goes to DONE.
- DONE: one cycle.
  - ack_o[granted]=1, pgaddr_o=captured address (alloc only; unchanged for free).
  - Pointer = granted+1, wrapping at g_num_ports. Go to IDLE.
- Latency: request seen in IDLE at cycle 0 -> mm_alloc_o at cycle 1 -> ack_o at cycle k+1, where k is the first WAIT cycle with mm_idle_i=1. Minimum 3 cycles.
- No back-to-back issue: a new grant occurs only from IDLE, so at most one operation is in flight.
- Requester deasserts its request in the cycle after ack. A request still high in IDLE is treated as new.
- nomem:
  - Alloc requests are not granted while mm_nomem_i=1 and stay pending; frees continue.
  - nomem_o = mm_nomem_i delayed by 1 cycle.
- Reset mid-operation: FSM returns to IDLE and no ack is produced. The allocator is reset from the same source.
- Port with req_alloc_i=req_free_i=1: free is served first; alloc is served on a later grant.

Decomposition:
- Package swc_alloc_pkg: FSM state enum, c_op_alloc/c_op_free constants, and the function f_rr_next(req, ptr) returning the next grant index.
- One sub-module, swc_rr_arbiter: pure round-robin grant with pointer register. The top keeps the FSM and allocator handshake.

Test Plan:
- Single alloc: port 0 alloc, usecnt=1, model allocator returns 0x005 after 3 cycles -> mm_alloc_o one pulse with mm_usecnt_o=1; ack_o=4'b0001 with pgaddr_o=0x005; no second pulse.
- Round-robin: ports 0..3 alloc simultaneously and held -> grants in order 0,1,2,3, each ack preceded by exactly one mm_alloc_o; pointer=0 after port 3.
- Fairness wrap: pointer=2, ports 0 and 3 requesting -> port 3 granted first, then port 0.
- nomem: mm_nomem_i=1, port 1 alloc and port 2 free 0x0A0 -> only mm_free_o with mm_pgaddr_o=0x0A0 and ack_o[2]; port 1 acked only after mm_nomem_i drops.
- Dual request: port 0 asserts both, free page 0x050 -> free acked first, alloc acked on a later grant.
- Reset in WAIT: rst_i for 1 cycle -> outputs 0, no ack_o, next request restarts from pointer 0.

Source files
------------

// File: rtl/swc_alloc_pkg.sv
// Shared definitions for the page-allocator front-end arbiter.
//   state_t    : handshake FSM states (IDLE -> ISSUE -> WAIT -> DONE)
//   grant_t    : registered grant payload (operation + port index)
//   f_rr_next  : first requesting port at or after a pointer, with wrap-around
package swc_alloc_pkg;

    localparam int unsigned c_max_ports = 16;
    localparam int unsigned c_idx_w     = 4;
    localparam int unsigned c_cnt_w     = 5;

    localparam logic c_op_alloc = 1'b0;
    localparam logic c_op_free  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic               op;
        logic [c_idx_w-1:0] port;
    } grant_t;

    // Scan n ports starting at ptr; ptr < n is assumed, so one subtraction wraps.
    // Returns 0 when nothing requests (the caller qualifies with an any-request flag).
    function automatic logic [c_idx_w-1:0] f_rr_next(
        input logic [c_max_ports-1:0] req,
        input logic [c_idx_w-1:0]     ptr,
        input logic [c_cnt_w-1:0]     n
    );
        logic [c_idx_w-1:0] grant;
        logic               found;
        logic [c_cnt_w-1:0] idx;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < int'(c_max_ports); i++) begin
            idx = c_cnt_w'(ptr) + c_cnt_w'(i);
            if (idx >= n) begin
                idx = idx - n;
            end
            if (!found && (c_cnt_w'(i) < n) && req[idx[c_idx_w-1:0]]) begin
                grant = idx[c_idx_w-1:0];
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/swc_rr_arbiter.sv
// Round-robin grant selection with its own pointer register.
//   clk_i, rst_i : clock, synchronous active-high reset (pointer -> 0)
//   req_i        : per-port eligible requests
//   adv_i        : advance the pointer past adv_idx_i (one cycle strobe)
//   adv_idx_i    : index of the port that was just served
//   valid_c_o    : combinational, some port is requesting
//   grant_c_o    : combinational, first requesting port at/after the pointer
module swc_rr_arbiter
    import swc_alloc_pkg::*;
#(
    parameter int unsigned g_num_ports = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [g_num_ports-1:0] req_i,
    input  logic                   adv_i,
    input  logic [c_idx_w-1:0]     adv_idx_i,
    output logic                   valid_c_o,
    output logic [c_idx_w-1:0]     grant_c_o
);

    logic [c_idx_w-1:0]     r_ptr;
    logic [c_max_ports-1:0] w_req_ext;

    assign w_req_ext = c_max_ports'(req_i);
    assign valid_c_o = |req_i;
    assign grant_c_o = f_rr_next(w_req_ext, r_ptr, c_cnt_w'(g_num_ports));

    // Pointer moves to the port after the one just served, wrapping at g_num_ports.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (adv_i) begin
            if (32'(adv_idx_i) == g_num_ports - 1) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= adv_idx_i + c_idx_w'(1);
            end
        end
    end

endmodule

// File: rtl/swc_page_alloc_arbiter.sv
// Arbitrates per-port page alloc/free requests onto the single-operation
// interface of swc_page_allocator, one operation in flight at a time.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   req_alloc_i/free_i  : per-port level requests, held until ack_o
//   req_usecnt_i        : per-port use count for alloc (port p at slice p)
//   req_pgaddr_i        : per-port page to free (port p at slice p)
//   ack_o               : one-cycle completion strobe to the granted port
//   pgaddr_o            : allocated page, valid with ack_o of an alloc
//   nomem_o             : mm_nomem_i delayed by one cycle
//   mm_alloc_o/free_o   : one-cycle operation pulses to the allocator
//   mm_usecnt_o/pgaddr_o: operation arguments, stable from issue to done
//   mm_pgaddr_i/_valid_i, mm_idle_i, mm_nomem_i : allocator status
module swc_page_alloc_arbiter
    import swc_alloc_pkg::*;
#(
    parameter int unsigned g_num_ports      = 4,
    parameter int unsigned g_page_addr_bits = 11,
    parameter int unsigned g_use_count_bits = 4
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [g_num_ports-1:0]                  req_alloc_i,
    input  logic [g_num_ports-1:0]                  req_free_i,
    input  logic [g_num_ports*g_use_count_bits-1:0] req_usecnt_i,
    input  logic [g_num_ports*g_page_addr_bits-1:0] req_pgaddr_i,
    output logic [g_num_ports-1:0]                  ack_o,
    output logic [g_page_addr_bits-1:0]             pgaddr_o,
    output logic                                    nomem_o,
    output logic                                    mm_alloc_o,
    output logic                                    mm_free_o,
    output logic [g_use_count_bits-1:0]             mm_usecnt_o,
    output logic [g_page_addr_bits-1:0]             mm_pgaddr_o,
    input  logic [g_page_addr_bits-1:0]             mm_pgaddr_i,
    input  logic                                    mm_pgaddr_valid_i,
    input  logic                                    mm_idle_i,
    input  logic                                    mm_nomem_i
);

    localparam int unsigned c_np = g_num_ports;
    localparam int unsigned c_aw = g_page_addr_bits;
    localparam int unsigned c_uw = g_use_count_bits;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [c_np-1:0]     w_elig;
    logic                w_any;
    logic [c_idx_w-1:0]  w_grant_idx;
    logic                w_grant_ok;
    logic                w_done;

    logic                w_sel_free;
    logic [c_uw-1:0]     w_sel_uc;
    logic [c_aw-1:0]     w_sel_pg;

    grant_t              r_grant,  w_grant_nxt;
    logic [c_aw-1:0]     r_cap,    w_cap_nxt;
    logic [c_uw-1:0]     r_uc,     w_uc_nxt;
    logic [c_aw-1:0]     r_pg,     w_pg_nxt;
    logic [c_np-1:0]     r_ack,    w_ack_nxt;
    logic [c_aw-1:0]     r_pgaddr, w_pgaddr_nxt;
    logic                r_alloc,  w_alloc_nxt;
    logic                r_free,   w_free_nxt;
    logic                r_nomem;

    // Frees are always eligible; allocs only while the allocator has pages.
    assign w_elig     = req_free_i | (req_alloc_i & {c_np{~mm_nomem_i}});
    assign w_grant_ok = (r_state == ST_IDLE) && mm_idle_i && w_any;
    assign w_done     = (r_state == ST_DONE);

    swc_rr_arbiter #(
        .g_num_ports (g_num_ports)
    ) u_rr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (w_elig),
        .adv_i     (w_done),
        .adv_idx_i (r_grant.port),
        .valid_c_o (w_any),
        .grant_c_o (w_grant_idx)
    );

    // Pick out the winning port's request fields.
    always_comb begin
        w_sel_free = 1'b0;
        w_sel_uc   = '0;
        w_sel_pg   = '0;
        for (int p = 0; p < int'(c_np); p++) begin
            if (c_idx_w'(p) == w_grant_idx) begin
                w_sel_free = req_free_i[p];
                w_sel_uc   = req_usecnt_i[p*c_uw +: c_uw];
                w_sel_pg   = req_pgaddr_i[p*c_aw +: c_aw];
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_grant_ok) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (mm_idle_i) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Output/datapath next values; outputs are registered so the pulse and
    // ack land in the ISSUE and DONE cycles respectively.
    always_comb begin
        w_grant_nxt  = r_grant;
        w_cap_nxt    = r_cap;
        w_uc_nxt     = r_uc;
        w_pg_nxt     = r_pg;
        w_ack_nxt    = '0;
        w_pgaddr_nxt = r_pgaddr;
        w_alloc_nxt  = 1'b0;
        w_free_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_ok) begin
                    // Free wins when a port raises both requests.
                    w_grant_nxt.port = w_grant_idx;
                    w_grant_nxt.op   = w_sel_free ? c_op_free : c_op_alloc;
                    w_uc_nxt         = w_sel_uc;
                    w_pg_nxt         = w_sel_pg;
                    w_alloc_nxt      = ~w_sel_free;
                    w_free_nxt       = w_sel_free;
                end
            end
            ST_WAIT: begin
                if (mm_pgaddr_valid_i) begin
                    w_cap_nxt = mm_pgaddr_i;
                end
                if (mm_idle_i) begin
                    for (int p = 0; p < int'(c_np); p++) begin
                        w_ack_nxt[p] = (c_idx_w'(p) == r_grant.port);
                    end
                    if (r_grant.op == c_op_alloc) begin
                        w_pgaddr_nxt = w_cap_nxt;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_grant  <= '0;
            r_cap    <= '0;
            r_uc     <= '0;
            r_pg     <= '0;
            r_ack    <= '0;
            r_pgaddr <= '0;
            r_alloc  <= 1'b0;
            r_free   <= 1'b0;
            r_nomem  <= 1'b0;
        end else begin
            r_grant  <= w_grant_nxt;
            r_cap    <= w_cap_nxt;
            r_uc     <= w_uc_nxt;
            r_pg     <= w_pg_nxt;
            r_ack    <= w_ack_nxt;
            r_pgaddr <= w_pgaddr_nxt;
            r_alloc  <= w_alloc_nxt;
            r_free   <= w_free_nxt;
            r_nomem  <= mm_nomem_i;
        end
    end

    assign ack_o       = r_ack;
    assign pgaddr_o    = r_pgaddr;
    assign nomem_o     = r_nomem;
    assign mm_alloc_o  = r_alloc;
    assign mm_free_o   = r_free;
    assign mm_usecnt_o = r_uc;
    assign mm_pgaddr_o = r_pg;

endmodule

// File: tb/tb_swc_page_alloc_arbiter.sv
// Bench for swc_page_alloc_arbiter: directed scenarios, a behavioural
// allocator, a cycle model of the arbiter and a per-cycle output compare.
module tb_swc_page_alloc_arbiter;

    localparam int NP = 4;
    localparam int AW = 11;
    localparam int UW = 4;
    localparam int DLY = 3;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic [NP-1:0]     req_alloc = '0;
    logic [NP-1:0]     req_free = '0;
    logic [NP*UW-1:0]  req_usecnt = '0;
    logic [NP*AW-1:0]  req_pgaddr = '0;
    logic [NP-1:0]     ack_o;
    logic [AW-1:0]     pgaddr_o;
    logic              nomem_o;
    logic              mm_alloc_o;
    logic              mm_free_o;
    logic [UW-1:0]     mm_usecnt_o;
    logic [AW-1:0]     mm_pgaddr_o;
    logic [AW-1:0]     mm_pgaddr_i = '0;
    logic              mm_valid = 1'b0;
    logic              mm_idle = 1'b1;
    logic              mm_nomem = 1'b0;

    always #5 clk = ~clk;

    swc_page_alloc_arbiter #(
        .g_num_ports      (NP),
        .g_page_addr_bits (AW),
        .g_use_count_bits (UW)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .req_alloc_i       (req_alloc),
        .req_free_i        (req_free),
        .req_usecnt_i      (req_usecnt),
        .req_pgaddr_i      (req_pgaddr),
        .ack_o             (ack_o),
        .pgaddr_o          (pgaddr_o),
        .nomem_o           (nomem_o),
        .mm_alloc_o        (mm_alloc_o),
        .mm_free_o         (mm_free_o),
        .mm_usecnt_o       (mm_usecnt_o),
        .mm_pgaddr_o       (mm_pgaddr_o),
        .mm_pgaddr_i       (mm_pgaddr_i),
        .mm_pgaddr_valid_i (mm_valid),
        .mm_idle_i         (mm_idle),
        .mm_nomem_i        (mm_nomem)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model of the arbiter ----------------
    int            cyc = 0;
    bit            m_init = 0;
    bit            m_rst_seen = 0;
    int            m_phase = 0;      // 0 ready, 1 issuing, 2 waiting, 3 completing
    int            m_ptr = 0;
    int            m_port = 0;
    bit            m_isfree = 0;
    logic [AW-1:0] m_cap = '0;
    logic [NP-1:0] e_ack = '0;
    logic          e_alloc = 0, e_free = 0, e_nomem = 0;
    logic [UW-1:0] e_uc = '0;
    logic [AW-1:0] e_pg = '0, e_pgaddr = '0;

    initial forever begin
        @(posedge clk);
        cyc++;
        m_rst_seen = rst_i;
        if (rst_i) begin
            m_init = 1; m_phase = 0; m_ptr = 0; m_cap = '0;
            e_ack = '0; e_alloc = 0; e_free = 0; e_nomem = 0;
            e_uc = '0; e_pg = '0; e_pgaddr = '0;
        end else begin
            e_nomem = mm_nomem;
            e_ack = '0; e_alloc = 0; e_free = 0;
            case (m_phase)
                0: if (mm_idle) begin
                    bit found;
                    found = 0;
                    for (int i = 0; i < NP; i++) begin
                        int p;
                        p = (m_ptr + i) % NP;
                        if (!found && (req_free[p] || (req_alloc[p] && !mm_nomem))) begin
                            found = 1; m_port = p; m_isfree = req_free[p];
                            e_uc = req_usecnt[p*UW +: UW];
                            e_pg = req_pgaddr[p*AW +: AW];
                        end
                    end
                    if (found) begin
                        e_alloc = !m_isfree; e_free = m_isfree; m_phase = 1;
                    end
                end
                1: m_phase = 2;
                2: begin
                    if (mm_valid) m_cap = mm_pgaddr_i;
                    if (mm_idle) begin
                        e_ack[m_port] = 1'b1;
                        if (!m_isfree) e_pgaddr = m_cap;
                        m_ptr = (m_port + 1) % NP;
                        m_phase = 3;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- behavioural allocator ----------------
    int            a_cnt = 0;
    bit            a_isalloc = 0;
    logic [AW-1:0] next_addr = '0;

    initial forever begin
        @(negedge clk);
        if (m_rst_seen) begin
            a_cnt = 0; mm_idle = 1; mm_valid = 0;
        end else if (mm_alloc_o || mm_free_o) begin
            a_cnt = DLY; a_isalloc = mm_alloc_o; mm_idle = 0; mm_valid = 0;
        end else if (a_cnt > 0) begin
            a_cnt--;
            if (a_cnt == 1 && a_isalloc) begin
                mm_valid = 1; mm_pgaddr_i = next_addr; next_addr = next_addr + 1'b1;
            end else if (a_cnt == 0) begin
                mm_valid = 0; mm_idle = 1;
            end
        end
    end

    // ---------------- per-cycle compare + pulse log ----------------
    int            n_pulses = 0;
    bit            last_free = 0;
    logic [AW-1:0] last_pg = '0;
    logic [UW-1:0] last_uc = '0;

    initial forever begin
        @(negedge clk);
        if (m_init) begin
            chk("ack_o",       64'(ack_o),       64'(e_ack));
            chk("pgaddr_o",    64'(pgaddr_o),    64'(e_pgaddr));
            chk("nomem_o",     64'(nomem_o),     64'(e_nomem));
            chk("mm_alloc_o",  64'(mm_alloc_o),  64'(e_alloc));
            chk("mm_free_o",   64'(mm_free_o),   64'(e_free));
            chk("mm_usecnt_o", 64'(mm_usecnt_o), 64'(e_uc));
            chk("mm_pgaddr_o", 64'(mm_pgaddr_o), 64'(e_pg));
        end
        if (mm_alloc_o || mm_free_o) begin
            n_pulses++; last_free = mm_free_o; last_pg = mm_pgaddr_o; last_uc = mm_usecnt_o;
        end
    end

    // ---------------- sequencer helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ack(input string name, output int port);
        port = -1;
        for (int i = 0; i < 60 && port < 0; i++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) if (ack_o[p]) port = p;
        end
        if (port < 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s: no ack within 60 cycles", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int port, t0, p0, acks;
        tick(3);
        chk("reset_ack",   64'(ack_o),      64'd0);
        chk("reset_alloc", 64'(mm_alloc_o), 64'd0);
        rst_i = 0;
        tick(2);

        // Round robin from pointer 0, all four ports held.
        next_addr = 11'h100;
        for (int p = 0; p < NP; p++) req_usecnt[p*UW +: UW] = UW'(p + 1);
        req_alloc = 4'hF;
        p0 = n_pulses;
        for (int i = 0; i < NP; i++) begin
            wait_ack("rr_ack", port);
            chk("rr_order", 64'(port), 64'(i));
            chk("rr_pgaddr", 64'(pgaddr_o), 64'(11'h100 + i));
            chk("rr_pulses", 64'(n_pulses - p0), 64'(i + 1));
            if (port >= 0) req_alloc[port] = 1'b0;
        end
        tick(2);

        // Single alloc on port 0: ack 5 cycles after the request, one pulse.
        next_addr = 11'h005;
        req_usecnt[0 +: UW] = 4'd1;
        p0 = n_pulses; t0 = cyc;
        req_alloc[0] = 1'b1;
        wait_ack("single_ack", port);
        chk("single_port",    64'(port), 64'd0);
        chk("single_pgaddr",  64'(pgaddr_o), 64'h005);
        chk("single_latency", 64'(cyc - t0), 64'd5);
        chk("single_usecnt",  64'(last_uc), 64'd1);
        req_alloc[0] = 1'b0;
        tick(5);
        chk("single_pulses",  64'(n_pulses - p0), 64'd1);

        // Serve port 1 to move the pointer to 2, then ports 0 and 3 compete.
        req_alloc[1] = 1'b1;
        wait_ack("fair_setup", port);
        req_alloc[1] = 1'b0;
        tick(1);
        req_alloc = 4'b1001;
        wait_ack("fair_first", port);
        chk("fair_first_port", 64'(port), 64'd3);
        if (port >= 0) req_alloc[port] = 1'b0;
        wait_ack("fair_second", port);
        chk("fair_second_port", 64'(port), 64'd0);
        req_alloc = '0;
        tick(2);

        // nomem: free on port 2 proceeds, alloc on port 1 waits.
        mm_nomem = 1'b1;
        req_pgaddr[2*AW +: AW] = 11'h0A0;
        req_alloc[1] = 1'b1;
        req_free[2]  = 1'b1;
        wait_ack("nomem_free", port);
        chk("nomem_free_port", 64'(port), 64'd2);
        chk("nomem_free_op",   64'(last_free), 64'd1);
        chk("nomem_free_pg",   64'(last_pg), 64'h0A0);
        req_free[2] = 1'b0;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack_o != 0) acks++;
        end
        chk("nomem_hold", 64'(acks), 64'd0);
        mm_nomem = 1'b0;
        wait_ack("nomem_alloc", port);
        chk("nomem_alloc_port", 64'(port), 64'd1);
        chk("nomem_alloc_op",   64'(last_free), 64'd0);
        req_alloc[1] = 1'b0;
        tick(2);

        // Dual request on port 0: free first, then alloc.
        req_pgaddr[0 +: AW] = 11'h050;
        req_alloc[0] = 1'b1;
        req_free[0]  = 1'b1;
        wait_ack("dual_free", port);
        chk("dual_free_port", 64'(port), 64'd0);
        chk("dual_free_op",   64'(last_free), 64'd1);
        chk("dual_free_pg",   64'(last_pg), 64'h050);
        req_free[0] = 1'b0;
        wait_ack("dual_alloc", port);
        chk("dual_alloc_port", 64'(port), 64'd0);
        chk("dual_alloc_op",   64'(last_free), 64'd0);
        req_alloc[0] = 1'b0;
        tick(2);

        // Reset while waiting on the allocator: no ack, pointer back to 0.
        p0 = n_pulses;
        req_alloc[2] = 1'b1;
        for (int i = 0; i < 20 && n_pulses == p0; i++) @(negedge clk);
        chk("rstw_issued", 64'(n_pulses - p0), 64'd1);
        tick(1);
        rst_i = 1'b1;
        req_alloc = '0;
        tick(1);
        rst_i = 1'b0;
        chk("rstw_ack",    64'(ack_o), 64'd0);
        chk("rstw_alloc",  64'(mm_alloc_o), 64'd0);
        chk("rstw_usecnt", 64'(mm_usecnt_o), 64'd0);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack_o != 0) acks++;
        end
        chk("rstw_noack", 64'(acks), 64'd0);
        req_alloc = 4'b1001;
        wait_ack("rstw_first", port);
        chk("rstw_first_port", 64'(port), 64'd0);
        if (port >= 0) req_alloc[port] = 1'b0;
        wait_ack("rstw_second", port);
        chk("rstw_second_port", 64'(port), 64'd3);
        req_alloc = '0;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
